// File: rtl/serial_payload_receiver.sv
// Receives a serial length field after the flag detector wakes it, then streams that many payload bits out registered.
// Optional even-parity trailer enabled by defining PAYLOAD_PARITY_EN; the default build has no parity state and parity_err tied low.
module serial_payload_receiver #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             wake_nbit,
  input  logic             wake_transmitter,
  output logic             transmitter_signal,
  output logic             get_back,
  output logic [LEN_W-1:0] payload_len,
  output logic             data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             parity_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LEN_DONE,
    S_WAIT_TX,
    S_DATA,
    S_PAR,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(LEN_W - 1);

`ifdef PAYLOAD_PARITY_EN
  localparam state_t S_END = S_PAR;
`else
  localparam state_t S_END = S_DONE;
`endif

  state_t           state;
  state_t           state_n;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-2:0] len_sr;
  logic [LEN_W-1:0] len_next;

  // The bits gathered so far plus the bit on the wire now form the complete length on the last LEN edge.
  assign len_next = {len_sr, serial_in};

  // NOTE: every flop below is reset to a known value so a mid-frame reset leaves nothing behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state <= state_n;
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_n unassigned (no latch).
    state_n = state;
    unique case (state)
      S_IDLE:     if (wake_nbit) state_n = S_LEN;
      S_LEN:      if (cnt == LEN_LAST) state_n = S_LEN_DONE;
      S_LEN_DONE: state_n = S_WAIT_TX;
      S_WAIT_TX: begin
        if (wake_transmitter) state_n = (payload_len == '0) ? S_END : S_DATA;
      end
      S_DATA:     if (cnt == payload_len - ONE) state_n = S_END;
      S_PAR:      state_n = S_DONE;
      S_DONE:     state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end

  always_comb begin
    transmitter_signal = (state == S_LEN_DONE);
    get_back           = (state == S_DONE);
    busy               = (state != S_IDLE);
  end

  // Length shifting, payload counting and the registered payload output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      len_sr      <= '0;
      payload_len <= '0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      unique case (state)
        S_IDLE: cnt <= '0;
        S_LEN: begin
          len_sr <= len_next[LEN_W-2:0];
          cnt    <= cnt + ONE;
          if (cnt == LEN_LAST) payload_len <= len_next;
        end
        S_WAIT_TX: if (wake_transmitter) cnt <= '0;
        S_DATA: begin
          data_out   <= serial_in;
          data_valid <= 1'b1;
          // Stops at payload_len-1, so a full-scale length never wraps the counter.
          cnt        <= cnt + ONE;
        end
        default: ;
      endcase
    end
  end

`ifdef PAYLOAD_PARITY_EN
  logic par_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_acc    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:    if (wake_nbit) parity_err <= 1'b0;
        S_WAIT_TX: if (wake_transmitter) par_acc <= 1'b0;
        S_DATA:    par_acc <= par_acc ^ serial_in;
        S_PAR:     parity_err <= par_acc ^ serial_in;
        default: ;
      endcase
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
